// File: rtl/pio_input_debouncer.sv
// pio_input_debouncer
//   Conditions raw board inputs (keys, slide switches) for an 8-bit
//   edge-capturing PIO input port. Every bit passes through a 2-flop
//   synchronizer and a stability counter. The debounced level moves only after
//   the synchronized input has disagreed with it for DEBOUNCE_CYCLES
//   consecutive clocks, so downstream edge logic sees one clean transition.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high reset
//   raw_in     : [WIDTH] asynchronous board inputs
//   bypass     : 1 = skip debounce, db_out follows the synchronizer
//   db_out     : [WIDTH] debounced level (register driven)
//   rise_pulse : [WIDTH] one-cycle strobe on accepted 0->1 of db_out
//   fall_pulse : [WIDTH] one-cycle strobe on accepted 1->0 of db_out

// Per-channel stability counter and debounced level.
module pio_db_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sync,
  input  logic i_bypass,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_db, r_rise, r_fall;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_db_nxt;

  // STABLE (sync == db) keeps the count at 0, so any single matching cycle
  // throws away the partial count. Bypass also pins the counter at 0.
  always_comb begin
    w_cnt_nxt = '0;
    w_db_nxt  = r_db;
    if (i_bypass) begin
      w_db_nxt = i_sync;
    end else if (i_sync != r_db) begin
      if (r_cnt == LAST) w_db_nxt  = i_sync;
      else               w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_db   <= RESET_LEVEL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_db   <= w_db_nxt;
      // Strobes are registered alongside db so they line up with the cycle
      // in which the new level first becomes visible.
      r_rise <= w_db_nxt & ~r_db;
      r_fall <= ~w_db_nxt & r_db;
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

module pio_input_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit RESET_LEVEL     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             bypass,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);
  // Counter must be able to hold DEBOUNCE_CYCLES-1.
  if (DEBOUNCE_CYCLES < 1 ||
      longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("pio_input_debouncer: DEBOUNCE_CYCLES out of range for CNT_W");
  end

  logic [WIDTH-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= {WIDTH{RESET_LEVEL}};
      r_sync2 <= {WIDTH{RESET_LEVEL}};
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    pio_db_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_sync  (r_sync2[g]),
      .i_bypass(bypass),
      .o_db    (db_out[g]),
      .o_rise  (rise_pulse[g]),
      .o_fall  (fall_pulse[g])
    );
  end
endmodule
